// File: rtl/hazard_irq_ctrl.sv
// Pipeline hazard and interrupt controller: load-use stall, branch flush,
// interrupt entry/return sequencing with saved EPC and an entry counter.
module hazard_irq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        IntReq,
  input  logic        IntEn,
  input  logic [4:0]  IDRs,
  input  logic [4:0]  IDRt,
  input  logic        IDUsesRs,
  input  logic        IDUsesRt,
  input  logic [4:0]  EXRd,
  input  logic        EXMemRead,
  input  logic        BranchTaken,
  input  logic        IDEret,
  input  logic [31:0] PCID,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IFIDClear,
  output logic        IDEXClear,
  output logic [1:0]  PCSel,
  output logic [31:0] EPC,
  output logic        IntAck,
  output logic        InService,
  output logic [7:0]  IntCount
);

  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } state_t;

  localparam logic [1:0] SEL_SEQ = 2'd0;
  localparam logic [1:0] SEL_BR  = 2'd1;
  localparam logic [1:0] SEL_VEC = 2'd2;
  localparam logic [1:0] SEL_EPC = 2'd3;

  state_t state;
  logic   pending;
  logic   load_use;
  logic   take;
  logic   do_eret;

  always_comb begin
    load_use = EXMemRead && (EXRd != 5'd0) &&
               ((IDUsesRs && (EXRd == IDRs)) || (IDUsesRt && (EXRd == IDRt)));
    take     = (state == RUN) && IntEn && (pending || IntReq) && !BranchTaken;
    // eret only retires when nothing of higher priority owns the cycle
    do_eret  = IDEret && (state == HANDLER) && !BranchTaken && !load_use;
  end

  assign InService = (state == HANDLER);

  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDClear = 1'b0;
    IDEXClear = 1'b0;
    PCSel     = SEL_SEQ;
    IntAck    = 1'b0;
    if (rst) begin
      IFIDClear = 1'b1;
      IDEXClear = 1'b1;
    end else if (take) begin
      IFIDClear = 1'b1;
      IDEXClear = 1'b1;
      PCSel     = SEL_VEC;
      IntAck    = 1'b1;
    end else if (BranchTaken) begin
      IFIDClear = 1'b1;
      IDEXClear = 1'b1;
      PCSel     = SEL_BR;
    end else if (load_use) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXClear = 1'b1;
    end else if (do_eret) begin
      IFIDClear = 1'b1;
      PCSel     = SEL_EPC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      pending  <= 1'b0;
      EPC      <= 32'd0;
      IntCount <= 8'd0;
    end else if (take) begin
      state    <= HANDLER;
      pending  <= 1'b0;
      EPC      <= PCID;
      IntCount <= IntCount + 8'd1;
    end else begin
      // requests that cannot be taken now (handler, branch, disabled) wait here
      if (IntReq) pending <= 1'b1;
      if (do_eret) state <= RUN;
    end
  end

endmodule
